// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects the four BASYS3 push-buttons and
// releases at most one single-cycle press pulse per clock, in U > D > L > R order.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNU_RAW,
  input  logic       BTND_RAW,
  input  logic       BTNL_RAW,
  input  logic       BTNR_RAW,
  output logic       BTNU,
  output logic       BTND,
  output logic       BTNL,
  output logic       BTNR,
  output logic [3:0] BTN_LEVEL,
  output logic       PRESS_ANY
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] stable;
  logic [3:0] rise;
  logic [3:0] pend;
  logic [3:0] pend_next;
  logic [3:0] grant;
  logic [3:0] pulse;
  logic       press_any_q;

  assign raw = {BTNU_RAW, BTND_RAW, BTNL_RAW, BTNR_RAW};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The counter only advances while the synchronised input disagrees with the
  // stable state; any agreeing sample restarts the stability window.
  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic             s;
    logic [CNT_W-1:0] c;
    logic             at_max;

    assign at_max = (c == CNT_MAX);

    always_ff @(posedge CLK) begin
      if (RESET) begin
        s <= 1'b0;
        c <= '0;
      end else if (sync2[i] == s) begin
        c <= '0;
      end else if (!at_max) begin
        c <= c + CNT_W'(1);
      end else begin
        s <= sync2[i];
        c <= '0;
      end
    end

    assign stable[i] = s;
    assign rise[i]   = ~s & sync2[i] & at_max;
  end

  // Grant looks only at presses already queued; a new rise on the same bit
  // re-queues it even when that bit is being granted this cycle.
  always_comb begin
    grant = 4'b0000;
    if (pend[3])      grant = 4'b1000;
    else if (pend[2]) grant = 4'b0100;
    else if (pend[1]) grant = 4'b0010;
    else if (pend[0]) grant = 4'b0001;
    pend_next = (pend & ~grant) | rise;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend        <= '0;
      pulse       <= '0;
      press_any_q <= 1'b0;
    end else begin
      pend        <= pend_next;
      pulse       <= grant;
      press_any_q <= |grant;
    end
  end

  assign {BTNU, BTND, BTNL, BTNR} = pulse;
  assign BTN_LEVEL                = stable;
  assign PRESS_ANY                = press_any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: table-driven level/queue checks,
// a pulse scoreboard, and a DEBOUNCE_CYCLES=2 instance for rapid re-presses.
`timescale 1ns/1ps
module tb_button_conditioner;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       btnu_raw = 1'b0, btnd_raw = 1'b0, btnl_raw = 1'b0, btnr_raw = 1'b0;
  logic       btnu, btnd, btnl, btnr, press_any;
  logic [3:0] btn_level;

  logic       d2_u_raw = 1'b0, d2_d_raw = 1'b0;
  logic       d2_u, d2_d, d2_l, d2_r, d2_any;
  logic [3:0] d2_level;

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .BTNU_RAW(btnu_raw), .BTND_RAW(btnd_raw), .BTNL_RAW(btnl_raw), .BTNR_RAW(btnr_raw),
    .BTNU(btnu), .BTND(btnd), .BTNL(btnl), .BTNR(btnr),
    .BTN_LEVEL(btn_level), .PRESS_ANY(press_any)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(2)) dut2 (
    .CLK(CLK), .RESET(RESET),
    .BTNU_RAW(d2_u_raw), .BTND_RAW(d2_d_raw), .BTNL_RAW(1'b0), .BTNR_RAW(1'b0),
    .BTNU(d2_u), .BTND(d2_d), .BTNL(d2_l), .BTNR(d2_r),
    .BTN_LEVEL(d2_level), .PRESS_ANY(d2_any)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         edge_n;
    logic [3:0] pulse;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int         test_id;
    logic [3:0] raw;
    int         k;
    logic [3:0] exp_level;
    logic [3:0] exp_pend;
    logic [3:0] exp_pulse;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic       u;
    logic       d;
    logic [3:0] exp_level;
    logic [3:0] exp_pend;
    logic [3:0] exp_pulse;
  } d2_vec_t;
  d2_vec_t d2_vecs[$];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_cnt);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] raw, output int e0);
    {btnu_raw, btnd_raw, btnl_raw, btnr_raw} = raw;
    e0 = edge_cnt + 1;
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge CLK);
  endtask

  task automatic add_vec(input int id, input logic [3:0] raw, input int k,
                         input logic [3:0] lvl, input logic [3:0] pnd, input logic [3:0] pls);
    vec_t v;
    v.test_id = id; v.raw = raw; v.k = k;
    v.exp_level = lvl; v.exp_pend = pnd; v.exp_pulse = pls;
    vecs.push_back(v);
  endtask

  task automatic add_d2(input logic u, input logic d, input logic [3:0] lvl,
                        input logic [3:0] pnd, input logic [3:0] pls);
    d2_vec_t v;
    v.u = u; v.d = d; v.exp_level = lvl; v.exp_pend = pnd; v.exp_pulse = pls;
    d2_vecs.push_back(v);
  endtask

  task automatic push_pulse(input int e, input logic [3:0] p);
    sb_t s;
    s.edge_n = e; s.pulse = p;
    sb.push_back(s);
  endtask

  task automatic run_table(input int id);
    int         e0;
    logic [3:0] raw;
    raw = 4'b0000;
    foreach (vecs[i]) if (vecs[i].test_id == id) raw = vecs[i].raw;
    apply_stimulus(raw, e0);
    foreach (vecs[i])
      if (vecs[i].test_id == id && vecs[i].exp_pulse != 4'b0000)
        push_pulse(e0 + vecs[i].k, vecs[i].exp_pulse);
    foreach (vecs[i]) begin
      if (vecs[i].test_id == id) begin
        wait_edge(e0 + vecs[i].k);
        check_output($sformatf("t%0d_level_k%0d", id, vecs[i].k), btn_level, vecs[i].exp_level);
        check_output($sformatf("t%0d_pend_k%0d", id, vecs[i].k), dut.pend, vecs[i].exp_pend);
      end
    end
  endtask

  task automatic release_all(input string name);
    int e;
    apply_stimulus(4'b0000, e);
    wait_edge(e + 7);
    check_output(name, btn_level, 4'b0000);
  endtask

  // Pulse monitor: every pulse must match the scoreboard head at its exact edge.
  always @(negedge CLK) begin
    logic [3:0] pulses;
    sb_t        e;
    pulses = {btnu, btnd, btnl, btnr};
    if (mon_en) begin
      check_output("press_any", 32'(press_any), 32'(|pulses));
      check_output("one_hot", 32'($countones(pulses) <= 1), 32'd1);
      while (sb.size() > 0 && sb[0].edge_n < edge_cnt) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed_pulse: got none, expected %b at edge %0d", sb[0].pulse, sb[0].edge_n);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].edge_n == edge_cnt) begin
        e = sb.pop_front();
        check_output("pulse", pulses, e.pulse);
      end else if (pulses != 4'b0000) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got %b, expected 0000 (edge %0d)", pulses, edge_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int e, r;

    // Clean press of L, then simultaneous press of all four.
    add_vec(1, 4'b0010,  4, 4'b0000, 4'b0000, 4'b0000);
    add_vec(1, 4'b0010,  5, 4'b0010, 4'b0010, 4'b0000);
    add_vec(1, 4'b0010,  6, 4'b0010, 4'b0000, 4'b0010);
    add_vec(1, 4'b0010, 20, 4'b0010, 4'b0000, 4'b0000);
    add_vec(3, 4'b1111,  4, 4'b0000, 4'b0000, 4'b0000);
    add_vec(3, 4'b1111,  5, 4'b1111, 4'b1111, 4'b0000);
    add_vec(3, 4'b1111,  6, 4'b1111, 4'b0111, 4'b1000);
    add_vec(3, 4'b1111,  7, 4'b1111, 4'b0011, 4'b0100);
    add_vec(3, 4'b1111,  8, 4'b1111, 4'b0001, 4'b0010);
    add_vec(3, 4'b1111,  9, 4'b1111, 4'b0000, 4'b0001);
    add_vec(3, 4'b1111, 14, 4'b1111, 4'b0000, 4'b0000);

    // DEBOUNCE_CYCLES=2 instance: U and D pressed 2 cycles, D released 2 and
    // pressed 2 again; D waits behind U and its second press is not lost.
    add_d2(1, 1, 4'b0000, 4'b0000, 4'b0000);
    add_d2(1, 1, 4'b0000, 4'b0000, 4'b0000);
    add_d2(0, 0, 4'b0000, 4'b0000, 4'b0000);
    add_d2(0, 0, 4'b1100, 4'b1100, 4'b0000);
    add_d2(0, 1, 4'b1100, 4'b0100, 4'b1000);
    add_d2(0, 1, 4'b0000, 4'b0000, 4'b0100);
    add_d2(0, 0, 4'b0000, 4'b0000, 4'b0000);
    add_d2(0, 0, 4'b0100, 4'b0100, 4'b0000);
    add_d2(0, 0, 4'b0100, 4'b0000, 4'b0100);
    for (int k = 9; k < 14; k++) add_d2(0, 0, 4'b0000, 4'b0000, 4'b0000);

    repeat (3) @(negedge CLK);
    check_output("reset_level", btn_level, 4'b0000);
    check_output("reset_pulses", {btnu, btnd, btnl, btnr}, 4'b0000);
    check_output("reset_press_any", 32'(press_any), 32'd0);
    check_output("reset_pend", dut.pend, 4'b0000);
    RESET = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);

    $display("[TB] clean press");
    run_table(1);
    release_all("t1_release_level");

    $display("[TB] bounce rejection");
    for (int n = 0; n < 2; n++) begin
      apply_stimulus(4'b1000, e);
      wait_edge(e + 1);
      apply_stimulus(4'b0000, e);
      wait_edge(e + 1);
    end
    wait_edge(e + 8);
    check_output("bounce_level", btn_level, 4'b0000);
    apply_stimulus(4'b1000, e);
    wait_edge(e + 2);
    apply_stimulus(4'b0000, r);
    wait_edge(e + 5);
    check_output("glitch3_level", btn_level, 4'b0000);
    wait_edge(e + 10);
    check_output("glitch3_level_late", btn_level, 4'b0000);

    $display("[TB] minimum-length press");
    apply_stimulus(4'b1000, e);
    push_pulse(e + 6, 4'b1000);
    wait_edge(e + 3);
    apply_stimulus(4'b0000, r);
    wait_edge(e + 4);
    check_output("min_press_level_k4", btn_level, 4'b0000);
    wait_edge(e + 5);
    check_output("min_press_level_k5", btn_level, 4'b1000);
    wait_edge(e + 8);
    check_output("min_press_level_k8", btn_level, 4'b1000);
    wait_edge(e + 9);
    check_output("min_press_level_k9", btn_level, 4'b0000);
    wait_edge(e + 12);

    $display("[TB] simultaneous press");
    run_table(3);
    release_all("t3_release_level");

    $display("[TB] release and re-press");
    apply_stimulus(4'b0001, e);
    push_pulse(e + 6, 4'b0001);
    wait_edge(e + 19);
    apply_stimulus(4'b0000, r);
    wait_edge(r + 4);
    check_output("t4_level_before_fall", btn_level, 4'b0001);
    wait_edge(r + 5);
    check_output("t4_level_after_fall", btn_level, 4'b0000);
    wait_edge(r + 9);
    apply_stimulus(4'b0001, e);
    push_pulse(e + 6, 4'b0001);
    wait_edge(e + 10);
    check_output("t4_level_repress", btn_level, 4'b0001);
    release_all("t4_release_level");

    $display("[TB] reset with presses pending");
    apply_stimulus(4'b1100, e);
    wait_edge(e + 5);
    check_output("t5_pend_before_reset", dut.pend, 4'b1100);
    RESET = 1'b1;
    r = e + 6;
    wait_edge(r);
    check_output("t5_pulses_after_reset", {btnu, btnd, btnl, btnr}, 4'b0000);
    check_output("t5_press_any_after_reset", 32'(press_any), 32'd0);
    check_output("t5_level_after_reset", btn_level, 4'b0000);
    check_output("t5_pend_after_reset", dut.pend, 4'b0000);
    RESET = 1'b0;
    push_pulse(r + 7, 4'b1000);
    push_pulse(r + 8, 4'b0100);
    wait_edge(r + 12);
    check_output("t5_level_reacquired", btn_level, 4'b1100);
    release_all("t5_release_level");

    $display("[TB] rapid re-press at DEBOUNCE_CYCLES=2");
    foreach (d2_vecs[k]) begin
      d2_u_raw = d2_vecs[k].u;
      d2_d_raw = d2_vecs[k].d;
      @(negedge CLK);
      check_output($sformatf("d2_pulse_k%0d", k), {d2_u, d2_d, d2_l, d2_r}, d2_vecs[k].exp_pulse);
      check_output($sformatf("d2_any_k%0d", k), 32'(d2_any), 32'(|d2_vecs[k].exp_pulse));
      check_output($sformatf("d2_level_k%0d", k), d2_level, d2_vecs[k].exp_level);
      check_output($sformatf("d2_pend_k%0d", k), dut2.pend, d2_vecs[k].exp_pend);
    end

    repeat (5) @(negedge CLK);
    check_output("scoreboard_drained", sb.size(), 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
